exu_flush_ctrl: RTL and testbench

Parametrised flush-stall controller for the EXU of the multi-cycle RV32I core. It merges flush requests from several sources (branch, jump, trap/fence) into one stall-slot counter. The counter is sampled once per instruction slot, on a configurable phase of the core's cycle counter. `flush_stall` is held high while slots remain, and the block reports completion, the winning source and a statistics count.

---
 rtl/exu_flush_ctrl.sv | 97 +++++++++
 tb/tb_exu_flush_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/exu_flush_ctrl.sv
// Flush-stall controller for the EXU: merges per-source stall requests into one
// slot counter that advances once per instruction slot on a chosen cycle phase.
module exu_flush_ctrl #(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned UPDATE_PHASE = 4,
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned REQ_W        = 2,
  parameter int unsigned STAT_W       = 16,
  localparam int unsigned SRC_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     hclk,
  input  logic                     hrst,
  input  logic [CNT_W-1:0]         cycle_cnt,
  input  logic [NUM_SRC*REQ_W-1:0] flush_req,
  input  logic                     flush_kill,
  output logic                     flush_stall,
  output logic [REQ_W-1:0]         slots_left,
  output logic                     flush_done,
  output logic [SRC_W-1:0]         flush_src,
  output logic [STAT_W-1:0]        flush_cnt
);

  logic [REQ_W-1:0]  rem_q, rem_d;
  logic              flush_stall_q, flush_stall_d;
  logic              flush_done_q, flush_done_d;
  logic [SRC_W-1:0]  flush_src_q, flush_src_d;
  logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [REQ_W-1:0]  max_req;
  logic [SRC_W-1:0]  win;
  logic [REQ_W-1:0]  dec;
  logic              update;
  logic              accept;

  // Arbitration: strict greater-than keeps the lowest index on ties.
  always_comb begin
    max_req = '0;
    win     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (flush_req[i*REQ_W +: REQ_W] > max_req) begin
        max_req = flush_req[i*REQ_W +: REQ_W];
        win     = SRC_W'(i);
      end
    end
  end

  always_comb begin
    dec           = (rem_q != '0) ? rem_q - REQ_W'(1) : '0;
    update        = (cycle_cnt == CNT_W'(UPDATE_PHASE)) && !flush_kill;
    accept        = update && (max_req > dec);

    rem_d         = rem_q;
    flush_src_d   = flush_src_q;
    flush_cnt_d   = flush_cnt_q;

    if (flush_kill) begin
      rem_d = '0;
    end else if (update) begin
      if (accept) begin
        rem_d       = max_req;
        flush_src_d = win;
        if (flush_cnt_q != {STAT_W{1'b1}}) begin
          flush_cnt_d = flush_cnt_q + STAT_W'(1);
        end
      end else begin
        rem_d = dec;
      end
    end

    flush_stall_d = (rem_d != '0);
    // Natural end only; a same-edge re-accept keeps rem_d nonzero so no pulse.
    flush_done_d  = update && (rem_q != '0) && (rem_d == '0);
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      rem_q         <= '0;
      flush_stall_q <= 1'b0;
      flush_done_q  <= 1'b0;
      flush_src_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      rem_q         <= rem_d;
      flush_stall_q <= flush_stall_d;
      flush_done_q  <= flush_done_d;
      flush_src_q   <= flush_src_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign flush_stall = flush_stall_q;
  assign slots_left  = rem_q;
  assign flush_done  = flush_done_q;
  assign flush_src   = flush_src_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_exu_flush_ctrl.sv
// Scoreboard bench for exu_flush_ctrl: a default instance plus a small
// instance (CNT_W=3, UPDATE_PHASE=0, STAT_W=2) share stimulus and a slot-level model.
module tb_exu_flush_ctrl;

  typedef struct {
    int stall;
    int slots;
    int done;
    int src;
    int cnt;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hrst;
  logic [3:0]  cc0;
  logic [2:0]  cc1;
  logic [5:0]  req;
  logic        kill;

  logic        stall0, done0, stall1, done1;
  logic [1:0]  slots0, src0, slots1, src1, cnt1;
  logic [15:0] cnt0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ctr   = 0;
  int   m_rem [2];
  int   m_src [2];
  int   m_cnt [2];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t e;

  always #5 hclk = ~hclk;

  exu_flush_ctrl dut0 (
    .hclk(hclk), .hrst(hrst), .cycle_cnt(cc0), .flush_req(req), .flush_kill(kill),
    .flush_stall(stall0), .slots_left(slots0), .flush_done(done0),
    .flush_src(src0), .flush_cnt(cnt0)
  );

  exu_flush_ctrl #(.CNT_W(3), .UPDATE_PHASE(0), .NUM_SRC(3), .REQ_W(2), .STAT_W(2)) dut1 (
    .hclk(hclk), .hrst(hrst), .cycle_cnt(cc1), .flush_req(req), .flush_kill(kill),
    .flush_stall(stall1), .slots_left(slots1), .flush_done(done1),
    .flush_src(src1), .flush_cnt(cnt1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Slot-level model: on an update slot the biggest request wins if it beats the decayed count.
  function automatic void model_step(input int id, input bit hit, input int cmax,
                                     input int r0, input int r1, input int r2, input bit k);
    int   mx;
    int   w;
    int   d;
    int   old;
    exp_t x;
    mx  = r0; w = 0;
    if (r1 > mx) begin mx = r1; w = 1; end
    if (r2 > mx) begin mx = r2; w = 2; end
    old    = m_rem[id];
    x.done = 0;
    if (k) begin
      m_rem[id] = 0;
    end else if (hit) begin
      d = (old > 0) ? old - 1 : 0;
      if (mx > d) begin
        m_rem[id] = mx;
        m_src[id] = w;
        if (m_cnt[id] < cmax) m_cnt[id] = m_cnt[id] + 1;
      end else begin
        m_rem[id] = d;
      end
      x.done = (old != 0 && m_rem[id] == 0) ? 1 : 0;
    end
    x.stall = (m_rem[id] != 0) ? 1 : 0;
    x.slots = m_rem[id];
    x.src   = m_src[id];
    x.cnt   = m_cnt[id];
    if (id == 0) q0.push_back(x);
    else         q1.push_back(x);
  endfunction

  task automatic drive(input int r0, input int r1, input int r2, input bit k);
    @(negedge hclk);
    cc0  = 4'(ctr);
    cc1  = 3'(ctr);
    req  = {2'(r2), 2'(r1), 2'(r0)};
    kill = k;
    model_step(0, (ctr % 16) == 4, 65535, r0, r1, r2, k);
    model_step(1, (ctr % 8) == 0, 3, r0, r1, r2, k);
    ctr++;
  endtask

  // Idle until the counter sits on phase ph, then apply the given inputs there.
  task automatic go(input int ph, input int r0, input int r1, input int r2, input bit k);
    while ((ctr % 16) != ph) drive(0, 0, 0, 0);
    drive(r0, r1, r2, k);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall0"}, int'(stall0), 0);
    chk({tag, "_slots0"}, int'(slots0), 0);
    chk({tag, "_done0"},  int'(done0),  0);
    chk({tag, "_src0"},   int'(src0),   0);
    chk({tag, "_cnt0"},   int'(cnt0),   0);
    chk({tag, "_stall1"}, int'(stall1), 0);
    chk({tag, "_slots1"}, int'(slots1), 0);
    chk({tag, "_done1"},  int'(done1),  0);
    chk({tag, "_src1"},   int'(src1),   0);
    chk({tag, "_cnt1"},   int'(cnt1),   0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0;
      m_src[i] = 0;
      m_cnt[i] = 0;
    end
  endtask

  task automatic rand_run(input int n);
    int r [3];
    for (int c = 0; c < n; c++) begin
      for (int s = 0; s < 3; s++) begin
        r[s] = $urandom_range(0, 7);
        if (r[s] > 3) r[s] = 0;
      end
      drive(r[0], r[1], r[2], ($urandom_range(0, 23) == 0));
    end
  endtask

  // Monitor: every clock the DUTs present a new output set; compare against the queue head.
  always @(posedge hclk) begin
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("d0_stall", int'(stall0), e.stall);
      chk("d0_slots", int'(slots0), e.slots);
      chk("d0_done",  int'(done0),  e.done);
      chk("d0_src",   int'(src0),   e.src);
      chk("d0_cnt",   int'(cnt0),   e.cnt);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("d1_stall", int'(stall1), e.stall);
      chk("d1_slots", int'(slots1), e.slots);
      chk("d1_done",  int'(done1),  e.done);
      chk("d1_src",   int'(src1),   e.src);
      chk("d1_cnt",   int'(cnt1),   e.cnt);
    end
  end

  initial begin
    hrst = 1'b1;
    kill = 1'b1;
    req  = '0;
    cc0  = '0;
    cc1  = '0;
    model_reset();
    #1;
    chk_zero("por");
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hrst = 1'b0;

    // Basic stall of 2 from source 1, then natural end.
    go(4, 0, 2, 0, 0);
    go(4, 0, 0, 0, 0);
    go(4, 0, 0, 0, 0);
    go(4, 0, 0, 0, 0);
    // Tie, re-arm by a larger source, non-accept at rem=2, extension at rem=1.
    go(4, 3, 0, 3, 0);
    go(4, 1, 0, 3, 0);
    go(4, 0, 0, 0, 0);
    go(4, 1, 0, 0, 0);
    go(4, 1, 0, 0, 0);
    go(4, 0, 0, 0, 0);
    // Kill off-phase and on-phase with requests present.
    go(4, 0, 3, 0, 0);
    go(2, 0, 3, 0, 1);
    go(4, 0, 0, 0, 0);
    go(4, 2, 2, 2, 1);
    // Request only off-phase.
    go(3, 2, 0, 0, 0);
    go(4, 0, 0, 0, 0);

    rand_run(3000);

    // Asynchronous reset in the middle of a stall.
    go(4, 0, 0, 3, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(posedge hclk);
    #3;
    hrst = 1'b1;
    #1;
    chk_zero("arst");
    model_reset();
    kill = 1'b1;
    req  = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hrst = 1'b0;

    rand_run(800);

    @(posedge hclk);
    #3;
    chk("q0_drain", q0.size(), 0);
    chk("q1_drain", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
